obi_spi_master_arbiter: RTL and testbench
=========================================

// Module: obi_spi_master_arbiter
// PURPOSE
//  Shares one OBI master port between NUM_REQ OBI requesters; port 0 is the SPI-slave OBI bridge, others DMA/debug.
//  Arbitrates address phase, tracks granted IDs in order, routes r_valid/r_data back to the issuer.
//  Sits between the requesters' obi_master_* ports and the system interconnect; single obi_aclk domain.
// PARAMETERS
//  NUM_REQ          2   number of requesters (2..8)
//  OBI_ADDR_WIDTH   32  address width
//  OBI_DATA_WIDTH   32  data width
//  MAX_OUTSTANDING  2   max granted-but-unanswered transactions (power of 2, >=1)
// PORTS
//  obi_aclk            in   1                      clock; all logic rising-edge
//  obi_aresetn         in   1                      asynchronous active-low reset
//  obi_slave_req       in   NUM_REQ                per-requester req
//  obi_slave_gnt       out  NUM_REQ                per-requester gnt
//  obi_slave_addr      in   NUM_REQ*ADDR_W         packed, requester i at [i*W +: W]
//  obi_slave_we        in   NUM_REQ                write enable
//  obi_slave_w_data    in   NUM_REQ*DATA_W         write data
//  obi_slave_be        in   NUM_REQ*4              byte enables
//  obi_slave_r_valid   out  NUM_REQ                response valid, one-hot
//  obi_slave_r_data    out  DATA_W                 response data, shared to all
//  obi_master_req      out  1                      downstream req
//  obi_master_gnt      in   1                      downstream gnt
//  obi_master_addr/we/w_data/be  out  ADDR_W/1/DATA_W/4  muxed from selected requester
//  obi_master_r_valid  in   1                      downstream response valid
//  obi_master_r_data   in   DATA_W                 downstream response data
//  err_unexp_rvalid    out  1                      sticky: r_valid with no outstanding ID
// BEHAVIOUR
//  Reset: state=ARB, rr_ptr=0, count=0, FIFO empty, err=0; all gnt/r_valid/obi_master_req=0.
//  FSM ARB: eligible = req & (count<MAX_OUTSTANDING); sel = first set req at/after rr_ptr (wrap).
//   Drive obi_master_req=1, payload of sel combinationally (zero-cycle latency).
//   gnt same cycle -> handshake, stay ARB; no gnt -> register sel, go HOLD.
//  HOLD: sel frozen, payload/req held from sel until gnt (OBI stability); other reqs ignored.
//  Handshake (req&gnt): obi_slave_gnt[sel]=1 this cycle only; push sel; rr_ptr<=(sel+1)%NUM_REQ; ->ARB.
//  count==MAX_OUTSTANDING: no new req from ARB; HOLD never entered with full FIFO.
//  Response: r_valid -> obi_slave_r_valid[head]=1 same cycle, pop; r_data passes straight through.
//  Push+pop same cycle: count unchanged. Pop uses pre-push head; r_valid on empty -> dropped, err=1.
//  Requester dropping req in HOLD is a protocol violation; arbiter keeps presenting stored payload.
//  Reset mid-transaction: all state cleared asynchronously; in-flight responses after reset set err.
//  count width $clog2(MAX_OUTSTANDING+1); FIFO pointers wrap modulo MAX_OUTSTANDING.
// CONFIGURATION
//  OBI_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, rr_ptr removed (SPI bridge top).
//  Undefined (default): round-robin as above. HOLD/ID tracking identical in both.
// STRUCTURE
//  Package obi_spi_arb_pkg: arb_state_e {ARB,HOLD}; function id width; req_id_t.
//  Sub-module obi_spi_arb_id_fifo: synchronous FIFO of req_id_t, depth MAX_OUTSTANDING, push/pop/full/empty/count.
//  Top: FSM, priority select, payload mux, response demux.
// TESTING
//  Reset asserted with req=2'b11 -> all outputs 0; release, gnt=1 -> req0 granted first, then req1, then req0.
//  req=2'b11, gnt low 3 cycles -> addr held at req0 value (e.g. 0x1000) all 3 cycles; req1 not granted.
//  MAX=2, gnt always 1, no r_valid -> two grants then obi_master_req=0; one r_valid -> third grant.
//  Grants to 1 then 0, r_valid twice (data 0xA5A5A5A5, 0x5A5A5A5A) -> r_valid[1] then r_valid[0], in order.
//  r_valid with empty FIFO -> no obi_slave_r_valid, err_unexp_rvalid=1 until reset.
//  With OBI_ARB_FIXED_PRIO_EN, req=2'b11 held, gnt=1 -> req0 granted every cycle, req1 starved.

Source files
------------

// File: rtl/obi_spi_arb_pkg.sv
// Shared types for the OBI requester arbiter: FSM states and the requester-ID type
// held in the in-order response-tracking FIFO.
package obi_spi_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   localparam int MAX_NUM_REQ = 8;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ID_W = id_width(MAX_NUM_REQ);

   typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/obi_spi_arb_id_fifo.sv
// In-order FIFO of granted requester IDs; the head names the owner of the next response.
// Head is read combinationally so the response can be routed in the same cycle.
module obi_spi_arb_id_fifo
   import obi_spi_arb_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  req_id_t          push_id,
   input  logic             pop,
   output req_id_t          head_id,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   req_id_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head_id = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/obi_spi_master_arbiter.sv
// Shares one OBI master port between NUM_REQ requesters (port 0 = SPI-slave bridge).
// Round-robin by default; define OBI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module obi_spi_master_arbiter
   import obi_spi_arb_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int OBI_ADDR_WIDTH  = 32,
   parameter int OBI_DATA_WIDTH  = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                              obi_aclk,
   input  logic                              obi_aresetn,
   input  logic [NUM_REQ-1:0]                obi_slave_req,
   output logic [NUM_REQ-1:0]                obi_slave_gnt,
   input  logic [NUM_REQ*OBI_ADDR_WIDTH-1:0] obi_slave_addr,
   input  logic [NUM_REQ-1:0]                obi_slave_we,
   input  logic [NUM_REQ*OBI_DATA_WIDTH-1:0] obi_slave_w_data,
   input  logic [NUM_REQ*4-1:0]              obi_slave_be,
   output logic [NUM_REQ-1:0]                obi_slave_r_valid,
   output logic [OBI_DATA_WIDTH-1:0]         obi_slave_r_data,
   output logic                              obi_master_req,
   input  logic                              obi_master_gnt,
   output logic [OBI_ADDR_WIDTH-1:0]         obi_master_addr,
   output logic                              obi_master_we,
   output logic [OBI_DATA_WIDTH-1:0]         obi_master_w_data,
   output logic [3:0]                        obi_master_be,
   input  logic                              obi_master_r_valid,
   input  logic [OBI_DATA_WIDTH-1:0]         obi_master_r_data,
   output logic                              err_unexp_rvalid
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   arb_state_e                state_reg, state_next;
   req_id_t                   sel_reg;
   req_id_t                   pick;
   req_id_t                   cur_sel;
   req_id_t                   head_id;
   logic [NUM_REQ-1:0]        eligible;
   logic                      master_req_int;
   logic                      handshake;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [CNT_W-1:0]          fifo_count;
   logic                      pop;
   logic                      err_reg;
   logic [OBI_ADDR_WIDTH-1:0] addr_reg;
   logic                      we_reg;
   logic [OBI_DATA_WIDTH-1:0] w_data_reg;
   logic [3:0]                be_reg;

   assign eligible = obi_slave_req & {NUM_REQ{~fifo_full}};

`ifdef OBI_ARB_FIXED_PRIO_EN
   always_comb begin
      pick = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (eligible[i]) pick = req_id_t'(i);
      end
   end
`else
   req_id_t              rr_ptr_reg;
   logic [2*NUM_REQ-1:0] rotated;
   logic                 found;

   // Rotating a doubled vector puts the requester at rr_ptr in bit 0.
   always_comb begin
      pick    = '0;
      found   = 1'b0;
      rotated = {eligible, eligible} >> rr_ptr_reg;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rotated[i]) begin
            pick  = req_id_t'((int'(rr_ptr_reg) + i) % NUM_REQ);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
      if (!obi_aresetn)  rr_ptr_reg <= '0;
      else if (handshake) rr_ptr_reg <= (cur_sel == req_id_t'(NUM_REQ - 1)) ? '0 : cur_sel + 1'b1;
   end
`endif

   always_comb begin
      state_next     = state_reg;
      cur_sel        = pick;
      master_req_int = 1'b0;
      case (state_reg)
         ARB: begin
            if (|eligible) begin
               master_req_int = 1'b1;
               if (!obi_master_gnt) state_next = HOLD;
            end
         end
         HOLD: begin
            cur_sel        = sel_reg;
            master_req_int = 1'b1;
            if (obi_master_gnt) state_next = ARB;
         end
         default: state_next = ARB;
      endcase
   end

   assign handshake      = master_req_int & obi_master_gnt & obi_aresetn;
   assign obi_master_req = master_req_int & obi_aresetn;

   // In HOLD the payload comes from registers so a requester misbehaving mid-wait cannot disturb it.
   always_comb begin
      if (state_reg == HOLD) begin
         obi_master_addr   = addr_reg;
         obi_master_we     = we_reg;
         obi_master_w_data = w_data_reg;
         obi_master_be     = be_reg;
      end else begin
         obi_master_addr   = obi_slave_addr[int'(cur_sel)*OBI_ADDR_WIDTH +: OBI_ADDR_WIDTH];
         obi_master_we     = obi_slave_we[cur_sel];
         obi_master_w_data = obi_slave_w_data[int'(cur_sel)*OBI_DATA_WIDTH +: OBI_DATA_WIDTH];
         obi_master_be     = obi_slave_be[int'(cur_sel)*4 +: 4];
      end
   end

   always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
      if (!obi_aresetn) begin
         state_reg  <= ARB;
         sel_reg    <= '0;
         addr_reg   <= '0;
         we_reg     <= 1'b0;
         w_data_reg <= '0;
         be_reg     <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ARB && master_req_int && !obi_master_gnt) begin
            sel_reg    <= cur_sel;
            addr_reg   <= obi_master_addr;
            we_reg     <= obi_master_we;
            w_data_reg <= obi_master_w_data;
            be_reg     <= obi_master_be;
         end
         if (obi_master_r_valid && fifo_empty) err_reg <= 1'b1;
      end
   end

   assign pop              = obi_master_r_valid & ~fifo_empty;
   assign obi_slave_r_data = obi_master_r_data;
   assign err_unexp_rvalid = err_reg;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
         assign obi_slave_gnt[gi]     = handshake && (cur_sel == req_id_t'(gi));
         assign obi_slave_r_valid[gi] = pop && obi_aresetn && (head_id == req_id_t'(gi));
      end
   endgenerate

   obi_spi_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (obi_aclk),
      .rst_n   (obi_aresetn),
      .push    (handshake),
      .push_id (cur_sel),
      .pop     (pop),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   logic unused_count;
   assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_obi_spi_master_arbiter.sv
// Directed bench for obi_spi_master_arbiter (NUM_REQ=2, MAX_OUTSTANDING=2, round-robin build);
// expected grants/responses are queued by the stimulus and consumed by a negedge monitor.
module tb_obi_spi_master_arbiter;

   localparam int NR = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [NR-1:0]  s_req = '0;
   logic [NR-1:0]  s_gnt;
   logic [NR*AW-1:0] s_addr = '0;
   logic [NR-1:0]  s_we = '0;
   logic [NR*DW-1:0] s_wdata = '0;
   logic [NR*4-1:0]  s_be = '0;
   logic [NR-1:0]  s_rvalid;
   logic [DW-1:0]  s_rdata;
   logic           m_req;
   logic           m_gnt = 1'b0;
   logic [AW-1:0]  m_addr;
   logic           m_we;
   logic [DW-1:0]  m_wdata;
   logic [3:0]     m_be;
   logic           m_rvalid = 1'b0;
   logic [DW-1:0]  m_rdata = '0;
   logic           err;

   typedef struct {
      logic [NR-1:0] v;
      logic [DW-1:0] d;
   } rsp_t;

   logic [NR-1:0] exp_gnt_q [$];
   rsp_t          exp_rsp_q [$];
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   obi_spi_master_arbiter #(
      .NUM_REQ         (NR),
      .OBI_ADDR_WIDTH  (AW),
      .OBI_DATA_WIDTH  (DW),
      .MAX_OUTSTANDING (2)
   ) dut (
      .obi_aclk           (clk),
      .obi_aresetn        (rst_n),
      .obi_slave_req      (s_req),
      .obi_slave_gnt      (s_gnt),
      .obi_slave_addr     (s_addr),
      .obi_slave_we       (s_we),
      .obi_slave_w_data   (s_wdata),
      .obi_slave_be       (s_be),
      .obi_slave_r_valid  (s_rvalid),
      .obi_slave_r_data   (s_rdata),
      .obi_master_req     (m_req),
      .obi_master_gnt     (m_gnt),
      .obi_master_addr    (m_addr),
      .obi_master_we      (m_we),
      .obi_master_w_data  (m_wdata),
      .obi_master_be      (m_be),
      .obi_master_r_valid (m_rvalid),
      .obi_master_r_data  (m_rdata),
      .err_unexp_rvalid   (err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every grant / response the DUT presents must match the queue head.
   always @(negedge clk) begin
      if (s_gnt != '0) begin
         if (exp_gnt_q.size() == 0) begin
            check("gnt_unexpected", 64'(s_gnt), 64'(0));
         end else begin
            logic [NR-1:0] e;
            e = exp_gnt_q.pop_front();
            $display("txn gnt act=%b exp=%b @%0t", s_gnt, e, $time);
            check("gnt_onehot", 64'(s_gnt), 64'(e));
         end
      end
      if (s_rvalid != '0) begin
         if (exp_rsp_q.size() == 0) begin
            check("rvalid_unexpected", 64'(s_rvalid), 64'(0));
         end else begin
            rsp_t r;
            r = exp_rsp_q.pop_front();
            $display("txn rsp act=%b/%h exp=%b/%h @%0t", s_rvalid, s_rdata, r.v, r.d, $time);
            check("rvalid_port", 64'(s_rvalid), 64'(r.v));
            check("rdata", 64'(s_rdata), 64'(r.d));
         end
      end
   end

   function automatic rsp_t mk_rsp(input logic [NR-1:0] v, input logic [DW-1:0] d);
      rsp_t r;
      r.v = v;
      r.d = d;
      return r;
   endfunction

   initial begin
      #1 rst_n = 1'b0;
      s_req   = 2'b11;
      s_addr  = {32'h0000_2000, 32'h0000_1000};
      s_we    = 2'b10;
      s_wdata = {32'h0000_0077, 32'h0000_0011};
      s_be    = 8'hF3;

      // Reset held with both requesters active
      @(negedge clk);
      check("rst_master_req", 64'(m_req), 64'(0));
      check("rst_gnt", 64'(s_gnt), 64'(0));
      check("rst_rvalid", 64'(s_rvalid), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      tick();

      // Cycle 1: req0 first
      rst_n = 1'b1;
      m_gnt = 1'b1;
      exp_gnt_q.push_back(2'b01);
      @(negedge clk);
      check("c1_addr", 64'(m_addr), 64'h1000);
      check("c1_be", 64'(m_be), 64'h3);
      tick();

      // Cycle 2: req1 next
      exp_gnt_q.push_back(2'b10);
      @(negedge clk);
      check("c2_addr", 64'(m_addr), 64'h2000);
      check("c2_we", 64'(m_we), 64'(1));
      check("c2_wdata", 64'(m_wdata), 64'h77);
      tick();

      // Cycle 3: two outstanding, nothing issued
      @(negedge clk);
      check("c3_full_req", 64'(m_req), 64'(0));
      check("c3_full_gnt", 64'(s_gnt), 64'(0));
      tick();

      // Cycle 4: first response returns to requester 0; still full this cycle
      m_rvalid = 1'b1;
      m_rdata  = 32'hA5A5_A5A5;
      exp_rsp_q.push_back(mk_rsp(2'b01, 32'hA5A5_A5A5));
      @(negedge clk);
      check("c4_full_req", 64'(m_req), 64'(0));
      tick();

      // Cycle 5: slot freed -> req0 granted again (rr wrapped)
      m_rvalid = 1'b0;
      exp_gnt_q.push_back(2'b01);
      @(negedge clk);
      tick();

      // Cycle 6: response goes to requester 1 (older outstanding)
      m_rvalid = 1'b1;
      m_rdata  = 32'h5A5A_5A5A;
      exp_rsp_q.push_back(mk_rsp(2'b10, 32'h5A5A_5A5A));
      @(negedge clk);
      tick();

      // Cycle 7: simultaneous grant (req1) and response (to req0)
      m_rdata = 32'h1234_5678;
      exp_gnt_q.push_back(2'b10);
      exp_rsp_q.push_back(mk_rsp(2'b01, 32'h1234_5678));
      @(negedge clk);
      tick();

      // Cycles 8-10: gnt withheld -> HOLD on req0, payload stable
      m_rvalid = 1'b0;
      m_gnt    = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            s_req  = 2'b10;
            s_addr = {32'h0000_2000, 32'hDEAD_0000};
         end
         @(negedge clk);
         check("hold_req", 64'(m_req), 64'(1));
         check("hold_addr", 64'(m_addr), 64'h1000);
         check("hold_gnt", 64'(s_gnt), 64'(0));
         tick();
      end

      // Cycle 11: gnt arrives -> held req0 transaction completes
      m_gnt = 1'b1;
      exp_gnt_q.push_back(2'b01);
      @(negedge clk);
      check("c11_addr", 64'(m_addr), 64'h1000);
      tick();

      // Cycle 12: full again, req1 waiting but not issued
      @(negedge clk);
      check("c12_full_req", 64'(m_req), 64'(0));
      tick();

      // Cycles 13-14: drain in order (1 then 0)
      s_req    = 2'b00;
      m_rvalid = 1'b1;
      m_rdata  = 32'hCAFE_F00D;
      exp_rsp_q.push_back(mk_rsp(2'b10, 32'hCAFE_F00D));
      @(negedge clk);
      tick();
      m_rdata = 32'h0BAD_BEEF;
      exp_rsp_q.push_back(mk_rsp(2'b01, 32'h0BAD_BEEF));
      @(negedge clk);
      tick();

      // Cycle 15: r_valid with nothing outstanding
      m_rdata = 32'h1111_1111;
      @(negedge clk);
      check("c15_rvalid_dropped", 64'(s_rvalid), 64'(0));
      check("c15_err_not_yet", 64'(err), 64'(0));
      tick();
      m_rvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("err_sticky", 64'(err), 64'(1));
         tick();
      end

      // Reset in the middle of a held transaction
      s_req  = 2'b11;
      s_addr = {32'h0000_2000, 32'h0000_1000};
      m_gnt  = 1'b0;
      @(negedge clk);
      check("pre_rst_hold_req", 64'(m_req), 64'(1));
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_req", 64'(m_req), 64'(0));
      check("midrst_err", 64'(err), 64'(0));
      tick();
      rst_n = 1'b1;
      m_gnt = 1'b1;
      exp_gnt_q.push_back(2'b01);
      @(negedge clk);
      check("post_rst_addr", 64'(m_addr), 64'h1000);
      tick();
      s_req = 2'b00;
      m_gnt = 1'b0;
      @(negedge clk);
      tick();

      check("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'(0));
      check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
